// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types and constants: ROB geometry, entry layout and
// the 1..DEPTH tag wrap helper.
package tomasulo_pkg;

  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned TAG_W     = 6;
  localparam int unsigned DATA_W    = 6;
  localparam int unsigned REG_W     = 4;
  localparam int unsigned NUM_REGS  = 10;
  localparam int unsigned IDX_W     = $clog2(ROB_DEPTH);

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

  function automatic rob_tag_t next_ptr(input rob_tag_t p);
    return (p == rob_tag_t'(ROB_DEPTH)) ? rob_tag_t'(1) : p + rob_tag_t'(1);
  endfunction

  // Tags run 1..DEPTH; the low bits give a storage slot, with tag DEPTH landing in slot 0.
  function automatic logic [IDX_W-1:0] slot_of(input rob_tag_t t);
    return t[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rob_wrap_ptr.sv
// 1..DEPTH wrapping pointer used for the ROB head and tail.
module rob_wrap_ptr
  import tomasulo_pkg::*;
(
  input  logic     clk1,
  input  logic     rst,
  input  logic     advance,
  output rob_tag_t ptr
);

  always_ff @(posedge clk1) begin
    if (rst)
      ptr <= rob_tag_t'(1);
    else if (advance)
      ptr <= next_ptr(ptr);
  end

endmodule

// File: rtl/rob_commit.sv
// 8-entry reorder buffer: in-order allocation, CDB result capture and
// in-order retirement of one ready head entry per cycle.
module rob_commit
  import tomasulo_pkg::*;
(
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output rob_tag_t          alloc_tag,
  input  logic              cdb_valid,
  input  rob_tag_t          cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              commit_valid,
  output logic              commit_we,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output rob_tag_t          commit_tag,
  output logic [3:0]        count,
  output logic              empty,
  output logic              full
);

  rob_entry_t entries [ROB_DEPTH];
  rob_tag_t   head;
  rob_tag_t   tail;
  rob_entry_t head_e;
  rob_entry_t cdb_e;
  logic       alloc_fire;
  logic       commit_fire;
  logic       cdb_fire;

  rob_wrap_ptr u_head (
    .clk1    (clk1),
    .rst     (rst),
    .advance (commit_fire),
    .ptr     (head)
  );

  rob_wrap_ptr u_tail (
    .clk1    (clk1),
    .rst     (rst),
    .advance (alloc_fire),
    .ptr     (tail)
  );

  always_comb begin
    full        = (count == 4'(ROB_DEPTH));
    empty       = (count == '0);
    alloc_ready = !full;
    alloc_tag   = tail;
    alloc_fire  = alloc_valid && !full;
    head_e      = entries[slot_of(head)];
    commit_fire = head_e.busy && head_e.ready;
    cdb_e       = entries[slot_of(cdb_tag)];
    cdb_fire    = cdb_valid && (cdb_tag != '0) && (cdb_tag <= rob_tag_t'(ROB_DEPTH))
                  && cdb_e.busy && !cdb_e.ready;
  end

  // Commit only touches a ready head, CDB only a busy non-ready entry and
  // allocation only a free slot, so the three updates never collide.
  always_ff @(posedge clk1) begin
    if (rst) begin
      entries      <= '{default: '0};
      count        <= '0;
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      commit_dest  <= '0;
      commit_value <= '0;
      commit_tag   <= '0;
    end else begin
      commit_valid <= commit_fire;
      commit_we    <= commit_fire && (head_e.dest != '0)
                      && (head_e.dest <= REG_W'(NUM_REGS));
      if (commit_fire) begin
        commit_dest                  <= head_e.dest;
        commit_value                 <= head_e.value;
        commit_tag                   <= head;
        entries[slot_of(head)].busy  <= 1'b0;
        entries[slot_of(head)].ready <= 1'b0;
      end
      if (cdb_fire) begin
        entries[slot_of(cdb_tag)].value <= cdb_value;
        entries[slot_of(cdb_tag)].ready <= 1'b1;
      end
      if (alloc_fire) begin
        entries[slot_of(tail)].busy  <= 1'b1;
        entries[slot_of(tail)].ready <= 1'b0;
        entries[slot_of(tail)].dest  <= alloc_dest;
      end
      count <= count + 4'(alloc_fire) - 4'(commit_fire);
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios then random traffic,
// compared against an in-order queue model of the reorder buffer.
module tb_rob_commit;

  logic       clk1;
  logic       rst;
  logic       alloc_valid;
  logic [3:0] alloc_dest;
  logic       alloc_ready;
  logic [5:0] alloc_tag;
  logic       cdb_valid;
  logic [5:0] cdb_tag;
  logic [5:0] cdb_value;
  logic       commit_valid;
  logic       commit_we;
  logic [3:0] commit_dest;
  logic [5:0] commit_value;
  logic [5:0] commit_tag;
  logic [3:0] count;
  logic       empty;
  logic       full;

  rob_commit dut (
    .clk1         (clk1),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_dest   (alloc_dest),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .commit_valid (commit_valid),
    .commit_we    (commit_we),
    .commit_dest  (commit_dest),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    int tag;
    int dest;
    int value;
    bit ready;
  } ment_t;

  ment_t mq[$];
  int    next_tag;
  int    exp_cv, exp_we, exp_dest, exp_val, exp_tag;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // One clock: drive inputs, check offered tag, advance the model, check outputs.
  task automatic step(input bit r, input bit av, input int ad,
                      input bit cv, input int ct, input int cval);
    bit do_commit;
    bit do_alloc;
    rst         = r;
    alloc_valid = av;
    alloc_dest  = 4'(ad);
    cdb_valid   = cv;
    cdb_tag     = 6'(ct);
    cdb_value   = 6'(cval);
    #1;
    if (!r) begin
      chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < 8));
      if (mq.size() < 8) chk("alloc_tag", 32'(alloc_tag), next_tag);
    end
    if (r) begin
      mq.delete();
      next_tag = 1;
      exp_cv = 0; exp_we = 0; exp_dest = 0; exp_val = 0; exp_tag = 0;
    end else begin
      do_commit = (mq.size() > 0) && mq[0].ready;
      do_alloc  = av && (mq.size() < 8);
      exp_cv = do_commit;
      exp_we = 0;
      if (do_commit) begin
        exp_we   = (mq[0].dest >= 1) && (mq[0].dest <= 10);
        exp_dest = mq[0].dest;
        exp_val  = mq[0].value;
        exp_tag  = mq[0].tag;
        void'(mq.pop_front());
      end
      if (cv)
        foreach (mq[i])
          if (mq[i].tag == ct && !mq[i].ready) begin
            mq[i].value = cval;
            mq[i].ready = 1'b1;
          end
      if (do_alloc) begin
        mq.push_back('{tag: next_tag, dest: ad, value: 0, ready: 1'b0});
        next_tag = (next_tag == 8) ? 1 : next_tag + 1;
      end
    end
    @(posedge clk1);
    #1;
    chk("count",        32'(count),        mq.size());
    chk("empty",        32'(empty),        32'(mq.size() == 0));
    chk("full",         32'(full),         32'(mq.size() == 8));
    chk("commit_valid", 32'(commit_valid), exp_cv);
    chk("commit_we",    32'(commit_we),    exp_we);
    chk("commit_dest",  32'(commit_dest),  exp_dest);
    chk("commit_value", 32'(commit_value), exp_val);
    chk("commit_tag",   32'(commit_tag),   exp_tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ct;
    bit rr;
    next_tag = 1;
    mq.delete();

    // Single instruction: alloc, CDB, commit, then empty.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 1, 45);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_commit_value", 32'(commit_value), 45);
    idle(1);
    chk("t1_empty", 32'(empty), 1);

    // Out-of-order results retire in order.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 3, 7);
    step(0, 0, 0, 1, 2, 5);
    step(0, 0, 0, 1, 1, 12);
    idle(4);

    // Fill, blocked 9th alloc, retire head, wrapped tail.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, i + 1, 0, 0, 0);
    chk("t3_full", 32'(full), 1);
    chk("t3_alloc_ready", 32'(alloc_ready), 0);
    step(0, 1, 9, 0, 0, 0);
    chk("t3_count_held", 32'(count), 8);
    step(0, 1, 9, 1, 1, 33);
    step(0, 1, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_wrap_tag", 32'(alloc_tag), 1);
    step(0, 1, 6, 0, 0, 0);

    // Simultaneous alloc+commit at count 5; ignored CDB writes.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, i + 2, 0, 0, 0);
    step(0, 0, 0, 1, 1, 20);
    step(0, 1, 8, 0, 0, 0);
    chk("t4_count_5", 32'(count), 5);
    step(0, 0, 0, 1, 0, 11);
    step(0, 0, 0, 1, 9, 12);
    step(0, 0, 0, 1, 2, 21);
    step(0, 0, 0, 1, 2, 63);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_first_write_wins", 32'(commit_value), 21);
    // Allocate tag T and CDB to T on the same edge: CDB ignored.
    step(0, 1, 5, 1, next_tag, 50);
    idle(3);

    // Destination 0 retires without ARF write.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 9);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_we_zero", 32'(commit_we), 0);

    // Reset with busy entries and a pending commit.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, i + 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 17);
    step(1, 1, 3, 1, 2, 4);
    chk("t6_count", 32'(count), 0);
    chk("t6_commit_valid", 32'(commit_valid), 0);
    chk("t6_alloc_tag", 32'(alloc_tag), 1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        ct = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        ct = $urandom_range(0, 15);
      rr = ($urandom_range(0, 149) == 0);
      step(rr, 1'($urandom), $urandom_range(0, 15), 1'($urandom), ct, $urandom_range(0, 63));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
